// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage: sequences up to three source reads over one RF port
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rn,
    input  logic [ADDR_W-1:0] in_rm,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic              in_use_rn,
    input  logic              in_use_rm,
    input  logic              in_use_rs,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [DATA_W-1:0] out_op_c,
    output logic [DATA_W-1:0] out_pc,
    output logic [CTRL_W-1:0] out_ctrl
);

    typedef enum logic [2:0] {IDLE, RD_RN, RD_RM, RD_RS, DONE} state_t;

    localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(15);

    state_t            state, state_nxt, first_state;
    logic [ADDR_W-1:0] rn_q, rm_q, rs_q;
    logic              use_rn_q, use_rm_q, use_rs_q;
    logic [DATA_W-1:0] pc_q, op_a_q, op_b_q, op_c_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              accept;
    logic              need_rm_q, need_rs_q;
    logic              in_need_rn, in_need_rm, in_need_rs;
    logic [DATA_W-1:0] pc_plus8;

    // r15 is served from the PC, so it never counts as a port read
    assign need_rm_q  = use_rm_q && (rm_q != PC_REG);
    assign need_rs_q  = use_rs_q && (rs_q != PC_REG);
    assign in_need_rn = in_use_rn && (in_rn != PC_REG);
    assign in_need_rm = in_use_rm && (in_rm != PC_REG);
    assign in_need_rs = in_use_rs && (in_rs != PC_REG);
    assign pc_plus8   = in_pc + DATA_W'(8);

    always_comb begin
        first_state = DONE;
        if (in_need_rn)      first_state = RD_RN;
        else if (in_need_rm) first_state = RD_RM;
        else if (in_need_rs) first_state = RD_RS;
    end

    always_comb begin
        state_nxt    = state;
        rf_read_addr = '0;
        in_ready     = rst_n && !flush && ((state == IDLE) || ((state == DONE) && out_ready));
        accept       = in_valid && in_ready;
        out_valid    = rst_n && !flush && (state == DONE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = first_state;
            end
            RD_RN: begin
                rf_read_addr = rn_q;
                if (need_rm_q)      state_nxt = RD_RM;
                else if (need_rs_q) state_nxt = RD_RS;
                else                state_nxt = DONE;
            end
            RD_RM: begin
                rf_read_addr = rm_q;
                state_nxt    = need_rs_q ? RD_RS : DONE;
            end
            RD_RS: begin
                rf_read_addr = rs_q;
                state_nxt    = DONE;
            end
            DONE: begin
                if (accept)         state_nxt = first_state;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rn_q     <= '0;
            rm_q     <= '0;
            rs_q     <= '0;
            use_rn_q <= 1'b0;
            use_rm_q <= 1'b0;
            use_rs_q <= 1'b0;
            pc_q     <= '0;
            ctrl_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_c_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rn_q     <= in_rn;
                rm_q     <= in_rm;
                rs_q     <= in_rs;
                use_rn_q <= in_use_rn;
                use_rm_q <= in_use_rm;
                use_rs_q <= in_use_rs;
                pc_q     <= in_pc;
                ctrl_q   <= in_ctrl;
                // unused operands are delivered as zero
                op_a_q   <= (in_use_rn && in_rn == PC_REG) ? pc_plus8 : '0;
                op_b_q   <= (in_use_rm && in_rm == PC_REG) ? pc_plus8 : '0;
                op_c_q   <= (in_use_rs && in_rs == PC_REG) ? pc_plus8 : '0;
            end else begin
                case (state)
                    RD_RN:   op_a_q <= rf_read_data;
                    RD_RM:   op_b_q <= rf_read_data;
                    RD_RS:   op_c_q <= rf_read_data;
                    default: ;
                endcase
            end
        end
    end

    assign out_op_a = op_a_q;
    assign out_op_b = op_b_q;
    assign out_op_c = op_c_q;
    assign out_pc   = pc_q;
    assign out_ctrl = ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rn, in_rm, in_rs;
    logic        in_use_rn, in_use_rm, in_use_rs;
    logic [31:0] in_pc;
    logic [15:0] in_ctrl;
    logic [3:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a, out_op_b, out_op_c, out_pc;
    logic [15:0] out_ctrl;

    logic [31:0] rf [16];
    assign rf_read_data = rf[rf_read_addr];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] pc;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    operand_fetch #(.DATA_W(32), .ADDR_W(4), .CTRL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rn(in_rn), .in_rm(in_rm), .in_rs(in_rs),
        .in_use_rn(in_use_rn), .in_use_rm(in_use_rm), .in_use_rs(in_use_rs),
        .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_op_c(out_op_c),
        .out_pc(out_pc), .out_ctrl(out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
                         input logic [2:0] use_bits, input logic [31:0] pc, input logic [15:0] ctrl);
        in_rn     = rn;
        in_rm     = rm;
        in_rs     = rs;
        in_use_rn = use_bits[2];
        in_use_rm = use_bits[1];
        in_use_rs = use_bits[0];
        in_pc     = pc;
        in_ctrl   = ctrl;
        in_valid  = 1'b1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] pc, input logic [15:0] ctrl);
        exp_t e;
        e.a = a; e.b = b; e.c = c; e.pc = pc; e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got handshake ctrl=%0h expected none", out_ctrl);
                end else begin
                    e = sb.pop_front();
                    check("out_a", out_op_a, e.a);
                    check("out_b", out_op_b, e.b);
                    check("out_c", out_op_c, e.c);
                    check("out_pc", out_pc, e.pc);
                    check("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        rf[4] = 32'hDEAD; rf[5] = 32'h55;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(4'd1, 4'd2, 4'd3, 3'b111, 32'h900, 16'h0009);

        // reset with in_valid held high
        repeat (2) step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op_a", out_op_a, 32'd0);
        check("rst_op_b", out_op_b, 32'd0);
        check("rst_op_c", out_op_c, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_ctrl", 32'(out_ctrl), 32'd0);
        check("rst_addr", 32'(rf_read_addr), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // three reads
        drive(4'd1, 4'd2, 4'd3, 3'b111, 32'h100, 16'h0001);
        step();
        push(32'h11, 32'h22, 32'h33, 32'h100, 16'h0001);
        in_valid = 1'b0;
        check("rd3_addr1", 32'(rf_read_addr), 32'd1);
        step();
        check("rd3_addr2", 32'(rf_read_addr), 32'd2);
        step();
        check("rd3_addr3", 32'(rf_read_addr), 32'd3);
        check("rd3_not_yet", 32'(out_valid), 32'd0);
        step();
        check("rd3_valid", 32'(out_valid), 32'd1);
        step();
        check("rd3_idle", 32'(out_valid), 32'd0);

        // r15 substitution with one real read
        drive(4'd15, 4'd4, 4'd7, 3'b110, 32'h1000, 16'h0002);
        step();
        push(32'h1008, 32'hDEAD, 32'h0, 32'h1000, 16'h0002);
        in_valid = 1'b0;
        check("r15_addr", 32'(rf_read_addr), 32'd4);
        step();
        check("r15_valid", 32'(out_valid), 32'd1);
        step();

        // r15 with PC wrap, no reads
        drive(4'd15, 4'd0, 4'd0, 3'b100, 32'hFFFF_FFFC, 16'h0003);
        step();
        push(32'h4, 32'h0, 32'h0, 32'hFFFF_FFFC, 16'h0003);
        in_valid = 1'b0;
        check("wrap_valid", 32'(out_valid), 32'd1);
        check("wrap_addr", 32'(rf_read_addr), 32'd0);
        step();

        // duplicate index read twice
        drive(4'd5, 4'd5, 4'd5, 3'b110, 32'h300, 16'h0004);
        step();
        push(32'h55, 32'h55, 32'h0, 32'h300, 16'h0004);
        in_valid = 1'b0;
        check("dup_addr1", 32'(rf_read_addr), 32'd5);
        step();
        check("dup_addr2", 32'(rf_read_addr), 32'd5);
        step();
        check("dup_valid", 32'(out_valid), 32'd1);
        step();

        // backpressure then back-to-back accept
        out_ready = 1'b0;
        drive(4'd1, 4'd0, 4'd0, 3'b100, 32'h400, 16'h0005);
        step();
        push(32'h11, 32'h0, 32'h0, 32'h400, 16'h0005);
        drive(4'd0, 4'd0, 4'd0, 3'b000, 32'h200, 16'hBEEF);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_op_a", out_op_a, 32'h11);
            check("bp_pc", out_pc, 32'h400);
            check("bp_ctrl", 32'(out_ctrl), 32'h5);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        step();
        push(32'h0, 32'h0, 32'h0, 32'h200, 16'hBEEF);
        in_valid = 1'b0;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_ctrl", 32'(out_ctrl), 32'hBEEF);
        step();
        check("b2b_idle", 32'(out_valid), 32'd0);

        // flush during RD_RM
        drive(4'd1, 4'd2, 4'd3, 3'b111, 32'h500, 16'h0006);
        step();
        in_valid = 1'b0;
        check("fl_addr1", 32'(rf_read_addr), 32'd1);
        step();
        check("fl_in_rm", 32'(rf_read_addr), 32'd2);
        flush = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fl_idle_addr", 32'(rf_read_addr), 32'd0);
        check("fl_idle_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("fl_no_valid", 32'(out_valid), 32'd0);
            step();
        end

        // flush in DONE with out_ready high
        drive(4'd0, 4'd0, 4'd0, 3'b000, 32'h600, 16'h0007);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("fld_valid", 32'(out_valid), 32'd0);
        check("fld_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fld_after", 32'(out_valid), 32'd0);
        check("fld_ready", 32'(in_ready), 32'd1);

        // reset during RD_RS
        drive(4'd1, 4'd2, 4'd3, 3'b111, 32'h700, 16'h0008);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mr_addr3", 32'(rf_read_addr), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mr_in_ready", 32'(in_ready), 32'd0);
        check("mr_valid", 32'(out_valid), 32'd0);
        step();
        check("mr_op_a", out_op_a, 32'd0);
        check("mr_op_b", out_op_b, 32'd0);
        check("mr_pc", out_pc, 32'd0);
        check("mr_ctrl", 32'(out_ctrl), 32'd0);
        check("mr_addr", 32'(rf_read_addr), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mr_rel_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("mr_lost", 32'(out_valid), 32'd0);
            step();
        end

        repeat (2) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
